// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
//
// Purpose:
//   NDIG-digit BCD event counter with a time-multiplexed seven-segment
//   display driver. The counter consumes single-cycle increment pulses
//   (typically from a debounced push button). The display is scanned one
//   digit per slot of DIV clock cycles. The last cycle of every slot drives
//   all anodes and segments inactive, so the previous digit's pattern never
//   ghosts onto the next anode.
//
// Parameters:
//   DIV        clk cycles per scan slot (>= 2)
//   NDIG       number of digits (1..8)
//   ACTIVE_LOW 1: an/seg/dp are low-active, 0: high-active
//   BLANK_LZ   1: suppress leading zeros (digit 0 is always shown)
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   inc_pulse  increment request, one count per high cycle
//   clr        synchronous counter clear (wins over inc_pulse)
//   an         registered digit enables, one-hot active during a slot
//   seg        registered segments {g,f,e,d,c,b,a}
//   dp         decimal point, permanently inactive
//   count_bcd  registered counter value, digit 0 in [3:0]
//   wrap       one-cycle pulse when the counter rolls from all-9s to 0
// -----------------------------------------------------------------------------
module bcd_scan_display #(
    parameter int DIV        = 50_000,
    parameter int NDIG       = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_pulse,
    input  logic              clr,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [4*NDIG-1:0] count_bcd,
    output logic              wrap
);

    localparam int DIV_W = $clog2(DIV);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    // Inactive levels; also used as XOR masks to convert an active-high
    // internal value to the pin polarity.
    localparam logic [NDIG-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};
    localparam logic [6:0]      SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic            DP_OFF  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [4*NDIG-1:0] count_q, count_d;
    logic              wrap_q, wrap_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    // -------------------------------------------------------------------------
    // Per-digit status flags (no chaining here, only local decodes)
    // -------------------------------------------------------------------------
    logic [NDIG-1:0] digit_is_nine;
    logic [NDIG-1:0] digit_is_zero;
    logic [NDIG-1:0] an_hot;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            logic [3:0] dig;
            assign dig               = count_q[4*gi +: 4];
            // >= rather than == so a corrupted digit still rolls over to 0.
            assign digit_is_nine[gi] = (dig >= 4'd9);
            assign digit_is_zero[gi] = (dig == 4'd0);
            assign an_hot[gi]        = (idx_q == IDX_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // BCD increment with full ripple carry inside one cycle
    // -------------------------------------------------------------------------
    logic [4*NDIG-1:0] count_inc;
    logic              carry_out;

    always_comb begin
        logic c;
        c         = inc_pulse;
        count_inc = count_q;
        for (int i = 0; i < NDIG; i++) begin
            if (c) begin
                if (digit_is_nine[i]) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                end
            end
            c = c && digit_is_nine[i];
        end
        // Carry out of the top digit means every digit was 9.
        carry_out = c;
    end

    // -------------------------------------------------------------------------
    // Leading-zero detection: hi_zero[i] is set when digit i and every
    // digit above it are zero.
    // -------------------------------------------------------------------------
    logic [NDIG-1:0] hi_zero;

    always_comb begin
        logic z;
        z       = 1'b1;
        hi_zero = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            z          = z && digit_is_zero[i];
            hi_zero[i] = z;
        end
    end

    // -------------------------------------------------------------------------
    // Digit selection for the current scan slot
    // -------------------------------------------------------------------------
    logic [3:0] digit_sel;
    logic       sel_blank;

    always_comb begin
        digit_sel = 4'd0;
        sel_blank = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit_sel = count_q[4*i +: 4];
                sel_blank = (BLANK_LZ != 0) && (i > 0) && hi_zero[i];
            end
        end
    end

    // Active-high {g,f,e,d,c,b,a} pattern for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic       tick;
    logic [6:0] seg_pat;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);

        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);

        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        // Clear wins: no increment and no wrap pulse when both are asserted.
        count_d   = clr ? '0 : count_inc;
        wrap_d    = carry_out && !clr;

        // The tick cycle blanks everything for one clock while the index
        // moves to the next digit; other cycles show the selected digit.
        seg_pat   = sel_blank ? 7'h00 : seg7(digit_sel);
        if (tick) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end else begin
            an_d  = an_hot ^ AN_OFF;
            seg_d = seg_pat ^ SEG_OFF;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            wrap_q    <= 1'b0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = DP_OFF;
    assign count_bcd = count_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_display
//
// Directed bench for bcd_scan_display with DIV=4, NDIG=4, ACTIVE_LOW=1.
// Two instances share the stimulus: dut (no leading-zero blanking) and
// dut_lz (leading-zero blanking enabled). Display expectations come from
// the bench's own edge counter k (edges since reset release) and a decimal
// model of the count.
// -----------------------------------------------------------------------------
module tb_bcd_scan_display;

    localparam int DIV  = 4;
    localparam int NDIG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inc_pulse;
    logic        clr;

    logic [3:0]  an, an_lz;
    logic [6:0]  seg, seg_lz;
    logic        dp, dp_lz;
    logic [15:0] cnt, cnt_lz;
    logic        wrap, wrap_lz;

    always #5 clk = ~clk;

    bcd_scan_display #(.DIV(DIV), .NDIG(NDIG), .ACTIVE_LOW(1), .BLANK_LZ(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .inc_pulse (inc_pulse),
        .clr       (clr),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .count_bcd (cnt),
        .wrap      (wrap)
    );

    bcd_scan_display #(.DIV(DIV), .NDIG(NDIG), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut_lz (
        .clk       (clk),
        .rst       (rst),
        .inc_pulse (inc_pulse),
        .clr       (clr),
        .an        (an_lz),
        .seg       (seg_lz),
        .dp        (dp_lz),
        .count_bcd (cnt_lz),
        .wrap      (wrap_lz)
    );

    int tests = 0;
    int fails = 0;
    int k     = -1;   // index of the last edge since reset release, -1 while in reset
    int model = 0;    // decimal value the counter should hold

    function automatic logic [6:0] pat(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;
            4: p = 7'h66;  5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;
            8: p = 7'h7F;  default: p = 7'h6F;
        endcase
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        if (r) k = -1;
        else   k++;
    endtask

    task automatic pulses(input int n);
        inc_pulse = 1'b1;
        repeat (n) begin
            step();
            model = (model + 1) % 10000;
        end
        inc_pulse = 1'b0;
    endtask

    // Expected display after edge k, assuming the count equalled model
    // before that edge.
    task automatic check_disp(input string tag);
        int pos, d, p10, dv;
        logic [3:0] ea;
        logic [6:0] es, esl;
        pos = k % DIV;
        d   = (k / DIV) % NDIG;
        p10 = 1;
        repeat (d) p10 = p10 * 10;
        if (pos == DIV - 1) begin
            ea  = 4'hF;
            es  = 7'h7F;
            esl = 7'h7F;
        end else begin
            ea  = 4'b0001 << d;
            ea  = ~ea;
            dv  = (model / p10) % 10;
            es  = ~pat(dv);
            esl = (d > 0 && model < p10) ? 7'h7F : es;
        end
        check({tag, "_an"},     {28'd0, an},     {28'd0, ea});
        check({tag, "_seg"},    {25'd0, seg},    {25'd0, es});
        check({tag, "_an_lz"},  {28'd0, an_lz},  {28'd0, ea});
        check({tag, "_seg_lz"}, {25'd0, seg_lz}, {25'd0, esl});
    endtask

    // Advance until the first active cycle of digit d's slot.
    task automatic wait_digit(input int d);
        for (int n = 0; n < 64; n++) begin
            step();
            if ((k % DIV) != DIV - 1 && ((k / DIV) % NDIG) == d) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        inc_pulse = 1'b0;
        clr       = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_an",    {28'd0, an},    32'hF);
        check("rst_seg",   {25'd0, seg},   32'h7F);
        check("rst_dp",    {31'd0, dp},    32'h1);
        check("rst_cnt",   {16'd0, cnt},   32'h0);
        check("rst_wrap",  {31'd0, wrap},  32'h0);
        check("rst_an_lz", {28'd0, an_lz}, 32'hF);

        // Scan sequence from reset release, through the idx wrap
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_disp("scan");
        end

        // Count and carry
        pulses(10);
        check("cnt_10",  {16'd0, cnt},  32'h0010);
        check("wrap_10", {31'd0, wrap}, 32'h0);
        wait_digit(1);
        check("dig1_seg", {25'd0, seg}, 32'h79);
        check_disp("dig1");
        pulses(90);
        check("cnt_100", {16'd0, cnt}, 32'h0100);

        // Wrap and back-to-back pulses
        pulses(9899);
        check("cnt_9999",  {16'd0, cnt},  32'h9999);
        check("wrap_9999", {31'd0, wrap}, 32'h0);
        inc_pulse = 1'b1;
        step();
        check("cnt_roll",  {16'd0, cnt},     32'h0000);
        check("wrap_roll", {31'd0, wrap},    32'h1);
        check("wrap_roll_lz", {31'd0, wrap_lz}, 32'h1);
        step();
        check("cnt_b2b1",  {16'd0, cnt},  32'h0001);
        check("wrap_b2b1", {31'd0, wrap}, 32'h0);
        step();
        check("cnt_b2b2",  {16'd0, cnt},  32'h0002);
        inc_pulse = 1'b0;
        step();
        check("cnt_idle",  {16'd0, cnt},  32'h0002);
        check("wrap_idle", {31'd0, wrap}, 32'h0);
        model = 2;

        // Clear priority
        pulses(40);
        check("cnt_42", {16'd0, cnt}, 32'h0042);
        inc_pulse = 1'b1;
        clr       = 1'b1;
        step();
        check("clr42_cnt",    {16'd0, cnt},    32'h0000);
        check("clr42_wrap",   {31'd0, wrap},   32'h0);
        check("clr42_cnt_lz", {16'd0, cnt_lz}, 32'h0000);
        inc_pulse = 1'b0;
        clr       = 1'b0;
        model     = 0;
        pulses(9999);
        check("cnt_9999b", {16'd0, cnt}, 32'h9999);
        inc_pulse = 1'b1;
        clr       = 1'b1;
        step();
        check("clr99_cnt",  {16'd0, cnt},  32'h0000);
        check("clr99_wrap", {31'd0, wrap}, 32'h0);
        inc_pulse = 1'b0;
        clr       = 1'b0;
        step();
        check("clr99_wrap2", {31'd0, wrap}, 32'h0);
        model = 0;

        // Leading-zero blanking at count 0007
        pulses(7);
        check("cnt_7", {16'd0, cnt_lz}, 32'h0007);
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            check_disp("lz");
        end

        // Reset during the digit-2 slot at count 0123
        clr = 1'b1;
        step();
        clr   = 1'b0;
        model = 0;
        pulses(123);
        check("cnt_123", {16'd0, cnt}, 32'h0123);
        wait_digit(2);
        step();
        rst = 1'b1;
        step();
        check("mid_cnt",   {16'd0, cnt},   32'h0);
        check("mid_an",    {28'd0, an},    32'hF);
        check("mid_seg",   {25'd0, seg},   32'h7F);
        check("mid_wrap",  {31'd0, wrap},  32'h0);
        check("mid_an_lz", {28'd0, an_lz}, 32'hF);
        model = 0;
        rst   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_disp("post");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Output-side counterpart to the button input path: consumes single-cycle increment pulses from the debounced button block.
- Maintains an NDIG-digit BCD event counter.
- Drives a time-multiplexed common-anode/cathode seven-segment display with per-digit scan and a one-cycle anti-ghost blanking guard.
- Sits between the debouncer's inc_pulse and the board display pins.

Parameters:
- DIV, 50_000: clk cycles per digit scan slot; scan tick when div_cnt == DIV-1; legal DIV >= 2.
- NDIG, 4: number of display digits; legal 1..8.
- ACTIVE_LOW, 1: 1 means an, seg and dp are driven low-active; 0 means high-active.
- BLANK_LZ, 0: 1 enables leading-zero blanking.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- inc_pulse, input, 1: single-cycle increment request; each high cycle counts once.
- clr, input, 1: synchronous counter clear.
- an, output, NDIG: digit enables, one-hot when active; registered.
- seg, output, 7: segments {g,f,e,d,c,b,a}; registered.
- dp, output, 1: decimal point, always inactive.
- count_bcd, output, 4*NDIG: counter value, digit0 in [3:0]; registered.
- wrap, output, 1: one-cycle pulse when the counter rolls from all-9s to all-0s.

Behaviour:
- Reset (rst=1 at a clk edge):
  - count_bcd=0, div_cnt=0, scan idx=0, wrap=0.
  - an=all inactive, seg=all inactive, dp inactive.
  - Reset mid-scan or mid-count aborts immediately; no partial state is kept.
- Counter:
  - On a clk edge with inc_pulse=1 and clr=0: digit0 += 1.
  - A digit at 9 becomes 0 and carries into the next digit; the carry ripple completes within the same edge.
  - count_bcd reflects the new value the cycle after the pulse.
  - All digits 9 plus inc: all digits become 0 and wrap=1 for exactly that next cycle; wrap=0 otherwise.
  - clr=1: count_bcd=0 next cycle; clr has priority over a simultaneous inc_pulse (no increment, no wrap).
  - Back-to-back inc_pulse on consecutive cycles: each counts; no pulse is lost.
  - Digit values are always 0..9; no other value is reachable.
- Scan:
  - div_cnt counts 0..DIV-1 free-running; tick = (div_cnt == DIV-1), then div_cnt wraps to 0.
  - On tick: idx advances (idx == NDIG-1 wraps to 0).
- Output register, loaded every cycle:
  - Tick cycle: an and seg load inactive (anti-ghost guard, exactly 1 clk).
  - Non-tick cycles: an loads one-hot idx active; seg loads the pattern of digit idx of the current count.
- Digit update latency: seg reflects a count change within 2 cycles of the inc_pulse edge (1 counter register + 1 output register). No tearing across digits within a slot beyond that.
- Segment patterns, active-high {g..a}: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. ACTIVE_LOW inverts these.
- Leading-zero blanking (BLANK_LZ=1):
  - A digit i>0 is blanked (seg inactive, an still active) when digit i and all higher digits are 0.
  - Digit 0 is never blanked.
- Slot timing: first slot after reset shows digit 0 from cycle 1 until the first tick; each later slot is DIV-1 active cycles plus 1 blank cycle.
- Single flat always-active design; no handshake back to the source: inc_pulse is accepted unconditionally.

Test Plan:
- Reset/scan (DIV=4, NDIG=4, ACTIVE_LOW=1): hold rst 3 cycles, release.
  - During rst: an=4'b1111, seg=7'h7F.
  - Then an=1110 with seg=~3F=7'h40 for 3 cycles, then 1111 for 1 cycle, then an=1101, etc.
  - idx wraps after digit 3.
- Count/carry: 10 inc_pulses → count_bcd=16'h0010; then 90 more → 16'h0100. Scanning digit 1 shows seg=~06 at the matching slot.
- Wrap: preload via 9999 pulses → 16'h9999; one more inc_pulse → 16'h0000 and wrap=1 for exactly one cycle; back-to-back pulses on consecutive cycles advance count by 2.
- clr priority: inc_pulse=1 and clr=1 in the same cycle at count 16'h0042 → count=16'h0000, wrap=0; clr at 16'h9999 with inc → 0000 and wrap stays 0.
- Blanking (BLANK_LZ=1), count=16'h0007:
  - Digits 1..3 slots: an active, seg=7'h7F.
  - Digit 0 slot: seg=~07=7'h78.
  - Count 0: digit 0 shows ~3F.
- Reset mid-operation: assert rst during a digit-2 slot at count 16'h0123 → next cycle count=0, an all inactive, div_cnt restarts; after release the scan starts at digit 0 with a full DIV-1 cycle slot.
